// File: rtl/sar_afe_emu.sv
// rtl/sar_afe_emu.sv - digital emulator of a SAR analog front end
// Sample-and-hold, pipelined DAC comparator and end-of-conversion checker.
module sar_afe_emu #(
  parameter int Width   = 10,
  parameter int Latency = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] vin_i,
  input  logic             sample_i,
  input  logic [Width-1:0] dac_i,
  input  logic             eoc_i,
  input  logic [Width-1:0] result_i,
  output logic             cmp_o,
  output logic [Width-1:0] held_o,
  output logic             busy_o,
  output logic [7:0]       ncmp_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, TRACK, CONVERT} state_e;

  state_e               state_q;
  logic [Width-1:0]     held_q;
  logic [Latency-1:0]   pipe_q;
  logic [Latency-1:0]   pipe_d;
  logic [7:0]           ncmp_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 err_q;

  // Stage 0 takes the raw compare; the last stage drives cmp_o.
  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = (held_q >= dac_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      held_q  <= '0;
      pipe_q  <= '0;
      ncmp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pipe_q <= pipe_d;
      if (sample_i) begin
        held_q <= vin_i;
      end
      case (state_q)
        IDLE: begin
          if (eoc_i) err_q <= 1'b1;
          if (sample_i) state_q <= TRACK;
        end
        TRACK: begin
          if (eoc_i) err_q <= 1'b1;
          if (!sample_i) begin
            state_q <= CONVERT;
            busy_q  <= 1'b1;
            ncmp_q  <= '0;
          end
        end
        CONVERT: begin
          // An eoc wins over a simultaneous sample request: accept, then track.
          if (eoc_i) begin
            done_q  <= 1'b1;
            pass_q  <= (result_i == held_q);
            busy_q  <= 1'b0;
            state_q <= sample_i ? TRACK : IDLE;
          end else begin
            if (ncmp_q != 8'hFF) ncmp_q <= ncmp_q + 8'd1;
            if (sample_i) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= TRACK;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmp_o  = pipe_q[Latency-1];
  assign held_o = held_q;
  assign busy_o = busy_q;
  assign ncmp_o = ncmp_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_sar_afe_emu.sv
// tb/tb_sar_afe_emu.sv - scoreboard bench for sar_afe_emu
// Latency=1 and Latency=3 instances share stimulus; a negedge monitor drains expectations.
module tb_sar_afe_emu;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] vin, dac, result;
  logic       sample, eoc;

  logic       cmp1, busy1, done1, pass1, err1;
  logic [9:0] held1;
  logic [7:0] ncmp1;
  logic       cmp3, busy3, done3, pass3, err3;
  logic [9:0] held3;
  logic [7:0] ncmp3;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  typedef struct {
    logic pass;
    int   ncmp;
  } done_t;

  exp_t  exq[$];
  done_t dq[$];

  sar_afe_emu #(.Width(10), .Latency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .vin_i(vin), .sample_i(sample), .dac_i(dac),
    .eoc_i(eoc), .result_i(result), .cmp_o(cmp1), .held_o(held1),
    .busy_o(busy1), .ncmp_o(ncmp1), .done_o(done1), .pass_o(pass1), .err_o(err1)
  );

  sar_afe_emu #(.Width(10), .Latency(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .vin_i(vin), .sample_i(sample), .dac_i(dac),
    .eoc_i(eoc), .result_i(result), .cmp_o(cmp3), .held_o(held3),
    .busy_o(busy3), .ncmp_o(ncmp3), .done_o(done3), .pass_o(pass3), .err_o(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sigval(input int s);
    case (s)
      0:  return int'(cmp1);
      1:  return int'(held1);
      2:  return int'(busy1);
      3:  return int'(ncmp1);
      4:  return int'(done1);
      5:  return int'(pass1);
      6:  return int'(err1);
      7:  return int'(cmp3);
      8:  return int'(held3);
      9:  return int'(busy3);
      10: return int'(ncmp3);
      11: return int'(done3);
      12: return int'(pass3);
      13: return int'(err3);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = exq.size() - 1; i >= 0; i--) begin
      if (exq[i].cyc == cyc) begin
        nvec++;
        if (sigval(exq[i].sig) != exq[i].val) begin
          nerr++;
          $display("FAIL %s cycle %0d: got %0h expected %0h", exq[i].name, cyc,
                   sigval(exq[i].sig), exq[i].val);
        end
        exq.delete(i);
      end
    end
    if (done1) begin
      nvec++;
      if (dq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_done cycle %0d: got done=1 expected no done", cyc);
      end else begin
        done_t d;
        d = dq.pop_front();
        if (pass1 !== d.pass || int'(ncmp1) != d.ncmp) begin
          nerr++;
          $display("FAIL done_check cycle %0d: got pass=%0b ncmp=%0d expected pass=%0b ncmp=%0d",
                   cyc, pass1, ncmp1, d.pass, d.ncmp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int s, input int v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.val = v; e.name = nm;
    exq.push_back(e);
  endtask

  task automatic dpush(input logic p, input int n);
    done_t d;
    d.pass = p; d.ncmp = n;
    dq.push_back(d);
  endtask

  task automatic expect_zero(input string tag);
    for (int s = 0; s < 14; s++) expect_now(s, 0, $sformatf("%s_sig%0d", tag, s));
  endtask

  task automatic sar_convert(input logic [9:0] v, input logic prev_pass);
    logic [9:0] acc;
    acc = '0;
    vin = v; sample = 1'b1;
    step(); step();
    sample = 1'b0;
    step();
    expect_now(2, 1, "sar_busy");
    expect_now(3, 0, "sar_ncmp0");
    for (int b = 9; b >= 0; b--) begin
      dac = acc | (10'd1 << b);
      step();
      if (cmp1) acc = dac;
    end
    expect_now(3, 10, "sar_ncmp");
    expect_now(5, int'(prev_pass), "sar_pass_hold");
    result = acc; eoc = 1'b1;
    dpush(1'b1, 10);
    step();
    eoc = 1'b0;
    expect_now(2, 0, "sar_busy_fall");
    expect_now(4, 1, "sar_done");
    expect_now(6, 0, "sar_err");
    step();
    expect_now(4, 0, "sar_done_once");
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    vin = 10'($urandom); dac = 10'($urandom); result = 10'($urandom);
    sample = 1'($urandom_range(0, 1)); eoc = 1'($urandom_range(0, 1));
    step(); step();
    expect_zero("reset");
    rst = 1'b0; sample = 1'b0; eoc = 1'b0; dac = '0; result = '0; vin = '0;
    step();

    // Sample and compare
    vin = 10'h2AA; sample = 1'b1;
    step(); step();
    sample = 1'b0;
    step();
    expect_now(1, 10'h2AA, "held");
    expect_now(2, 1, "busy_rise");
    expect_now(3, 0, "ncmp_clear");
    dac = 10'h200; step(); expect_now(0, 1, "cmp_200"); expect_now(3, 1, "ncmp1");
    dac = 10'h300; step(); expect_now(0, 0, "cmp_300"); expect_now(3, 2, "ncmp2");
    dac = 10'h2AA; step(); expect_now(0, 1, "cmp_2aa"); expect_now(3, 3, "ncmp3");

    // Mismatching result
    result = 10'h2AB; eoc = 1'b1;
    dpush(1'b0, 3);
    step();
    eoc = 1'b0;
    expect_now(4, 1, "mm_done");
    expect_now(5, 0, "mm_pass");
    expect_now(2, 0, "mm_busy");
    step();
    expect_now(4, 0, "mm_done_fall");
    expect_now(3, 3, "ncmp_hold_idle");
    expect_now(5, 0, "mm_pass_hold");

    // Closed loop conversions
    sar_convert(10'h1C7, 1'b0);
    sar_convert(10'h000, 1'b1);
    sar_convert(10'h3FF, 1'b1);

    // eoc in IDLE
    eoc = 1'b1; step(); eoc = 1'b0;
    expect_now(6, 1, "err_eoc_idle");
    expect_now(4, 0, "no_done_idle_eoc");
    rst = 1'b1; step(); rst = 1'b0;
    expect_now(6, 0, "err_cleared");

    // Abort from CONVERT
    vin = 10'h155; sample = 1'b1; dac = '0;
    step(); step();
    sample = 1'b0;
    step(); step(); step();
    sample = 1'b1;
    step();
    sample = 1'b0;
    expect_now(2, 0, "abort_busy");
    expect_now(6, 1, "abort_err");
    expect_now(4, 0, "abort_no_done");
    step();
    expect_now(2, 1, "abort_was_track");
    expect_now(6, 1, "err_sticky");

    // Reset mid-CONVERT
    rst = 1'b1; step(); rst = 1'b0;
    expect_zero("rst_conv");
    step();
    expect_now(4, 0, "rst_no_done");
    expect_now(2, 0, "rst_idle");

    // Latency=3 step response
    vin = 10'h100; dac = '0; sample = 1'b1;
    step();
    sample = 1'b0;
    step();
    step(); step(); step();
    expect_now(7, 1, "lat3_pre");
    dac = 10'h3FF;
    step(); expect_now(7, 1, "lat3_e1"); expect_now(0, 0, "lat1_e1");
    step(); expect_now(7, 1, "lat3_e2");
    step(); expect_now(7, 0, "lat3_e3");

    // eoc and sample together in CONVERT
    result = 10'h100; eoc = 1'b1; sample = 1'b1;
    dpush(1'b1, 6);
    step();
    eoc = 1'b0; sample = 1'b0;
    expect_now(11, 1, "both_done3");
    expect_now(13, 0, "both_err3");
    expect_now(6, 0, "both_err1");
    step();
    expect_now(9, 1, "both_went_track");
    expect_now(6, 0, "both_err_after");

    // eoc held two cycles
    eoc = 1'b1;
    dpush(1'b1, 0);
    step(); step();
    eoc = 1'b0;
    expect_now(6, 1, "eoc_long_err");
    expect_now(4, 0, "eoc_long_one_done");
    step(); step();

    nvec++;
    if (exq.size() != 0) begin
      nerr++;
      $display("FAIL pending_expect: got %0d unchecked expected 0", exq.size());
    end
    nvec++;
    if (dq.size() != 0) begin
      nerr++;
      $display("FAIL missing_done: got %0d outstanding expected 0", dq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
